// File: rtl/coin_pkg.sv
// Shared types and constants for the keypad scanner in front of the coin-charger control FSM.
package coin_pkg;

    localparam int KP_ROWS    = 4;
    localparam int KP_COLS    = 4;
    localparam int KEY_CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DEB,
        HELD,
        REL_DEB
    } kp_state_e;

    typedef enum logic [1:0] {
        SW_NONE,
        SW_ONE,
        SW_MULTI
    } sweep_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizers for asynchronous inputs: a vector variant for plain levels and a
// single-bit variant that also produces a one-cycle rising-edge pulse.
module sync_vec #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_o = stage_q[STAGES-1];

endmodule

module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic level;
    logic prev_q;

    sync_vec #(
        .WIDTH  (1),
        .STAGES (STAGES)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (async_i),
        .sync_o  (level)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise_o = level & ~prev_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: one column per scan tick, whole-sweep debounce, one event per press.
// ICLK is only ever sampled as a level; all state lives on OCLK.
module keypad_scanner
    import coin_pkg::*;
#(
    parameter int DEB_SWEEPS  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  OCLK,
    input  logic                  reset,
    input  logic                  ICLK,
    input  logic [KP_ROWS-1:0]    row_n,
    output logic [KP_COLS-1:0]    col_n,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_held
);

    localparam int ROW_W = $clog2(KP_ROWS);
    localparam int COL_W = $clog2(KP_COLS);
    localparam logic [3:0]         DEB_N   = 4'(DEB_SWEEPS);
    localparam logic [KP_COLS-1:0] COL_ONE = KP_COLS'(1);
    localparam logic [COL_W-1:0]   COL_END = COL_W'(KP_COLS - 1);

    logic                  scan_tick;
    logic [KP_ROWS-1:0]    row_sync;

    logic [COL_W-1:0]      col_idx_q;
    logic [KP_COLS-1:0]    col_n_q;
    logic [1:0]            acc_cnt_q;
    logic [KEY_CODE_W-1:0] acc_code_q;
    kp_state_e             state_q;
    logic [3:0]            deb_cnt_q;
    logic [KEY_CODE_W-1:0] cand_q;
    logic [KEY_CODE_W-1:0] key_code_q;
    logic                  key_valid_q;
    logic                  key_held_q;

    logic [2:0]            row_pop;
    logic [ROW_W-1:0]      row_hit;
    logic [2:0]            cnt_sum;
    logic [1:0]            acc_cnt_d;
    logic [KEY_CODE_W-1:0] acc_code_d;
    sweep_e                sweep_res;
    logic                  sweep_end;
    logic [COL_W-1:0]      col_inc;
    logic [3:0]            deb_inc;

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_iclk_sync (
        .clk_i   (OCLK),
        .rst_ni  (reset),
        .async_i (ICLK),
        .rise_o  (scan_tick)
    );

    sync_vec #(
        .WIDTH  (KP_ROWS),
        .STAGES (SYNC_STAGES)
    ) u_row_sync (
        .clk_i   (OCLK),
        .rst_ni  (reset),
        .async_i (row_n),
        .sync_o  (row_sync)
    );

    // The sweep result includes the column being sampled right now, so the FSM sees the whole sweep.
    always_comb begin
        row_pop = '0;
        row_hit = '0;
        for (int r = 0; r < KP_ROWS; r++) begin
            if (!row_sync[r]) begin
                row_pop = row_pop + 3'd1;
                row_hit = ROW_W'(r);
            end
        end
        cnt_sum    = {1'b0, acc_cnt_q} + row_pop;
        acc_cnt_d  = (cnt_sum >= 3'd2) ? 2'd2 : cnt_sum[1:0];
        acc_code_d = acc_code_q;
        if (row_pop == 3'd1) begin
            acc_code_d = {col_idx_q, row_hit};
        end
        case (acc_cnt_d)
            2'd0:    sweep_res = SW_NONE;
            2'd1:    sweep_res = SW_ONE;
            default: sweep_res = SW_MULTI;
        endcase
        sweep_end = scan_tick && (col_idx_q == COL_END);
        col_inc   = col_idx_q + 1'b1;
        deb_inc   = deb_cnt_q + 4'd1;
    end

    always_ff @(posedge OCLK or negedge reset) begin
        if (!reset) begin
            col_idx_q   <= '0;
            col_n_q     <= ~COL_ONE;
            acc_cnt_q   <= '0;
            acc_code_q  <= '0;
            state_q     <= IDLE;
            deb_cnt_q   <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (scan_tick) begin
                col_idx_q <= col_inc;
                col_n_q   <= ~(COL_ONE << col_inc);
                if (!sweep_end) begin
                    acc_cnt_q  <= acc_cnt_d;
                    acc_code_q <= acc_code_d;
                end else begin
                    acc_cnt_q  <= '0;
                    acc_code_q <= '0;
                    case (state_q)
                        IDLE: begin
                            if (sweep_res == SW_ONE) begin
                                if (DEB_N == 4'd1) begin
                                    key_code_q  <= acc_code_d;
                                    key_valid_q <= 1'b1;
                                    key_held_q  <= 1'b1;
                                    state_q     <= HELD;
                                end else begin
                                    cand_q    <= acc_code_d;
                                    deb_cnt_q <= 4'd1;
                                    state_q   <= PRESS_DEB;
                                end
                            end
                        end
                        PRESS_DEB: begin
                            if (sweep_res == SW_ONE && acc_code_d == cand_q) begin
                                if (deb_inc == DEB_N) begin
                                    key_code_q  <= cand_q;
                                    key_valid_q <= 1'b1;
                                    key_held_q  <= 1'b1;
                                    deb_cnt_q   <= '0;
                                    state_q     <= HELD;
                                end else begin
                                    deb_cnt_q <= deb_inc;
                                end
                            end else begin
                                deb_cnt_q <= '0;
                                state_q   <= IDLE;
                            end
                        end
                        HELD: begin
                            if (sweep_res == SW_NONE) begin
                                if (DEB_N == 4'd1) begin
                                    key_held_q <= 1'b0;
                                    state_q    <= IDLE;
                                end else begin
                                    deb_cnt_q <= 4'd1;
                                    state_q   <= REL_DEB;
                                end
                            end
                        end
                        REL_DEB: begin
                            if (sweep_res == SW_NONE) begin
                                if (deb_inc == DEB_N) begin
                                    key_held_q <= 1'b0;
                                    deb_cnt_q  <= '0;
                                    state_q    <= IDLE;
                                end else begin
                                    deb_cnt_q <= deb_inc;
                                end
                            end else begin
                                deb_cnt_q <= '0;
                                state_q   <= HELD;
                            end
                        end
                        default: begin
                            deb_cnt_q <= '0;
                            state_q   <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign col_n     = col_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
